fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage between the PC register and decode. Computes next_pc
//  (sequential or branch redirect), drives synchronous instruction-memory
//  address, tracks the in-flight fetch, and owns the IF/ID pipeline register.
//  Provides stall hold with a one-entry instruction hold buffer, and squashes
//  wrong-path fetches on branch redirect or pipeline flush.
// PARAMETERS
//  address_width  12            PC / IMEM byte-address width
//  instr_width    32            instruction width
//  NOP_INSTR      32'h00000013  bubble encoding (addi x0,x0,0)
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-high reset
//  pc_current     in   AW  current PC from PC register
//  stall          in   1   hazard-unit stall of IF and IF/ID
//  flush          in   1   pipeline restart (PC register reloads 0 same edge)
//  branch_taken   in   1   EX-resolved redirect
//  branch_target  in   AW  redirect address
//  imem_rdata     in   IW  IMEM data, 1-cycle latency after imem_addr
//  next_pc        out  AW  to PC register next_pc
//  pc_stall       out  1   to PC register stall
//  imem_addr      out  AW  IMEM read address
//  if_id_pc       out  AW  PC of instruction in IF/ID
//  if_id_instr    out  IW  instruction in IF/ID
//  if_id_valid    out  1   IF/ID holds a real (non-bubble) instruction
// BEHAVIOUR
//  Combinational: imem_addr = pc_current.
//   next_pc = branch_taken ? branch_target : pc_current + 4, mod 2^AW (wraps).
//   pc_stall = stall & ~branch_taken & ~flush (redirect never blocked).
//  State: fetch_pc_q, fetch_valid_q (in-flight fetch), hold_instr, hold_valid,
//   IF/ID regs. fetch_instr = hold_valid ? hold_instr : imem_rdata.
//  Reset (async): fetch_pc_q=0, fetch_valid_q=0, hold_valid=0, hold_instr=0,
//   if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0.
//  Priority per edge: reset > flush > branch_taken > stall > advance.
//  flush or branch_taken: fetch_valid_q<=0; hold_valid<=0; if_id_valid<=0;
//   if_id_instr<=NOP_INSTR; if_id_pc<=fetch_pc_q; fetch_pc_q<=pc_current.
//   Stall ignored that edge.
//  stall: fetch_pc_q, fetch_valid_q, IF/ID all hold. If !hold_valid:
//   hold_instr<=imem_rdata, hold_valid<=fetch_valid_q. If hold_valid: hold.
//  advance: if_id_pc<=fetch_pc_q; if_id_valid<=fetch_valid_q;
//   if_id_instr<=fetch_valid_q ? fetch_instr : NOP_INSTR; hold_valid<=0;
//   fetch_pc_q<=pc_current; fetch_valid_q<=1.
//  Latency: address on imem_addr at edge N -> in IF/ID after edge N+1.
//  After reset release: first edge launches fetch of PC 0 (bubble in IF/ID);
//   PC 0 valid in IF/ID after 2nd edge.
//  Multi-cycle stall: data captured once in first stalled cycle; no
//   instruction lost or duplicated regardless of stall length.
//  Reset mid-stall or mid-redirect: all state cleared immediately; hold lost.
// TESTING
//  Reset, no stall, imem returns addr-tagged data -> if_id_pc 0,4,8,...
//   if_id_valid=1 from 2nd edge, instr matches tag each cycle.
//  Stall 3 cycles at if_id_pc=8 -> IF/ID holds 8; after release 0xC then 0x10
//   with correct data; pc_stall=1 exactly during stall.
//  branch_taken, target 0x40, while IF/ID=0x10 -> next_pc=0x40; next 2 IF/ID
//   slots bubble (valid=0, instr=0x13); then 0x40 valid.
//  branch_taken and stall same cycle -> pc_stall=0, redirect taken, bubbles
//   as above, hold_valid cleared.
//  pc_current=0xFFC (AW=12), no branch -> next_pc=0x000.
//  flush during stall, then reset mid-run -> IF/ID bubbles, 0 refetched;
//   reset forces all outputs to reset values without waiting for clk.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: next-PC selection, IMEM addressing, in-flight fetch
// tracking, one-entry stall hold buffer and the IF/ID pipeline register.
module fetch_stage #(
   parameter int                     address_width = 12,
   parameter int                     instr_width   = 32,
   parameter logic [instr_width-1:0] NOP_INSTR     = 32'h00000013
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [address_width-1:0] pc_current,
   input  logic                     stall,
   input  logic                     flush,
   input  logic                     branch_taken,
   input  logic [address_width-1:0] branch_target,
   input  logic [instr_width-1:0]   imem_rdata,
   output logic [address_width-1:0] next_pc,
   output logic                     pc_stall,
   output logic [address_width-1:0] imem_addr,
   output logic [address_width-1:0] if_id_pc,
   output logic                     if_id_valid,
   output logic [instr_width-1:0]   if_id_instr
);

   localparam logic [address_width-1:0] PC_STEP = address_width'(32'd4);

   logic [address_width-1:0] fetch_pc_q, fetch_pc_d;
   logic                     fetch_valid_q, fetch_valid_d;
   logic [instr_width-1:0]   hold_instr_q, hold_instr_d;
   logic                     hold_valid_q, hold_valid_d;
   logic [address_width-1:0] if_id_pc_q, if_id_pc_d;
   logic                     if_id_valid_q, if_id_valid_d;
   logic [instr_width-1:0]   if_id_instr_q, if_id_instr_d;
   logic [instr_width-1:0]   fetch_instr_s;

   assign imem_addr   = pc_current;
   assign next_pc     = branch_taken ? branch_target : (pc_current + PC_STEP);
   // A redirect must always load the PC register, so it overrides the stall.
   assign pc_stall    = stall & ~branch_taken & ~flush;
   assign if_id_pc    = if_id_pc_q;
   assign if_id_valid = if_id_valid_q;
   assign if_id_instr = if_id_instr_q;

   // Next-state selection: redirect squashes, stall parks IMEM data, else advance.
   always_comb begin
      fetch_instr_s = hold_valid_q ? hold_instr_q : imem_rdata;
      fetch_pc_d    = fetch_pc_q;
      fetch_valid_d = fetch_valid_q;
      hold_instr_d  = hold_instr_q;
      hold_valid_d  = hold_valid_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_valid_d = if_id_valid_q;
      if_id_instr_d = if_id_instr_q;
      if (flush || branch_taken) begin
         fetch_valid_d = 1'b0;
         hold_valid_d  = 1'b0;
         if_id_valid_d = 1'b0;
         if_id_instr_d = NOP_INSTR;
         if_id_pc_d    = fetch_pc_q;
         fetch_pc_d    = pc_current;
      end else if (stall) begin
         // IMEM data is only valid for one cycle; capture it on the first stalled edge.
         if (!hold_valid_q) begin
            hold_instr_d = imem_rdata;
            hold_valid_d = fetch_valid_q;
         end else begin
            hold_instr_d = hold_instr_q;
            hold_valid_d = hold_valid_q;
         end
      end else begin
         if_id_pc_d    = fetch_pc_q;
         if_id_valid_d = fetch_valid_q;
         if_id_instr_d = fetch_valid_q ? fetch_instr_s : NOP_INSTR;
         hold_valid_d  = 1'b0;
         fetch_pc_d    = pc_current;
         fetch_valid_d = 1'b1;
      end
   end

   // State registers with asynchronous reset to an empty pipeline.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q    <= '0;
         fetch_valid_q <= 1'b0;
         hold_instr_q  <= '0;
         hold_valid_q  <= 1'b0;
         if_id_pc_q    <= '0;
         if_id_valid_q <= 1'b0;
         if_id_instr_q <= NOP_INSTR;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         fetch_valid_q <= fetch_valid_d;
         hold_instr_q  <= hold_instr_d;
         hold_valid_q  <= hold_valid_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_valid_q <= if_id_valid_d;
         if_id_instr_q <= if_id_instr_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: models the PC register and a 1-cycle IMEM
// returning address-tagged words, and checks IF/ID contents step by step.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk;
   logic        reset;
   logic [11:0] pc_current;
   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [11:0] branch_target;
   logic [31:0] imem_rdata;
   logic [11:0] next_pc;
   logic        pc_stall;
   logic [11:0] imem_addr;
   logic [11:0] if_id_pc;
   logic        if_id_valid;
   logic [31:0] if_id_instr;

   int checks   = 0;
   int failures = 0;

   fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .pc_current    (pc_current),
      .stall         (stall),
      .flush         (flush),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_rdata    (imem_rdata),
      .next_pc       (next_pc),
      .pc_stall      (pc_stall),
      .imem_addr     (imem_addr),
      .if_id_pc      (if_id_pc),
      .if_id_valid   (if_id_valid),
      .if_id_instr   (if_id_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] tag(input logic [11:0] a);
      return {20'hA5000, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic ifid(input string name, input logic [11:0] pc, input logic v, input logic [31:0] ins);
      chk({name, ".pc"}, 32'(if_id_pc), 32'(pc));
      chk({name, ".valid"}, 32'(if_id_valid), 32'(v));
      chk({name, ".instr"}, if_id_instr, ins);
   endtask

   // One clock: PC register and IMEM respond to the edge, then inputs settle.
   task automatic tick();
      logic [11:0] p_n;
      logic [31:0] r_n;
      if (reset || flush)     p_n = 12'h000;
      else if (branch_taken)  p_n = branch_target;
      else if (stall)         p_n = pc_current;
      else                    p_n = pc_current + 12'h004;
      r_n = tag(pc_current);
      @(posedge clk);
      #1;
      pc_current = p_n;
      imem_rdata = r_n;
   endtask

   initial begin
      logic [11:0] saved_pc;
      reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
      branch_target = 12'h000; pc_current = 12'h000; imem_rdata = 32'h0;
      #2;
      ifid("reset", 12'h000, 1'b0, NOP);
      chk("reset.imem_addr", 32'(imem_addr), 32'h0);
      chk("reset.next_pc", 32'(next_pc), 32'h4);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;

      // Straight-line fetch
      tick(); ifid("e1", 12'h000, 1'b0, NOP);
      tick(); ifid("e2", 12'h000, 1'b1, tag(12'h000));
      tick(); ifid("e3", 12'h004, 1'b1, tag(12'h004));
      tick(); ifid("e4", 12'h008, 1'b1, tag(12'h008));

      // Three-cycle stall at IF/ID=8
      stall = 1'b1; #1;
      chk("stall.pc_stall", 32'(pc_stall), 32'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         ifid("stall.hold", 12'h008, 1'b1, tag(12'h008));
         chk("stall.pc_stall_in", 32'(pc_stall), 32'h1);
      end
      stall = 1'b0; #1;
      chk("unstall.pc_stall", 32'(pc_stall), 32'h0);
      tick(); ifid("rel1", 12'h00C, 1'b1, tag(12'h00C));
      tick(); ifid("rel2", 12'h010, 1'b1, tag(12'h010));

      // Branch redirect to 0x40
      branch_taken = 1'b1; branch_target = 12'h040; #1;
      chk("br.next_pc", 32'(next_pc), 32'h040);
      tick(); branch_taken = 1'b0;
      ifid("br.bub1", 12'h014, 1'b0, NOP);
      tick(); ifid("br.bub2", 12'h018, 1'b0, NOP);
      tick(); ifid("br.tgt", 12'h040, 1'b1, tag(12'h040));

      // Stall fills the hold buffer, then branch+stall must discard it
      stall = 1'b1;
      tick(); ifid("bs.hold", 12'h040, 1'b1, tag(12'h040));
      branch_taken = 1'b1; branch_target = 12'h080; #1;
      chk("bs.pc_stall", 32'(pc_stall), 32'h0);
      chk("bs.next_pc", 32'(next_pc), 32'h080);
      tick(); branch_taken = 1'b0; stall = 1'b0;
      ifid("bs.bub1", 12'h044, 1'b0, NOP);
      tick(); ifid("bs.bub2", 12'h048, 1'b0, NOP);
      tick(); ifid("bs.tgt", 12'h080, 1'b1, tag(12'h080));

      // PC wrap at the top of the address space
      saved_pc = pc_current;
      pc_current = 12'hFFC; #1;
      chk("wrap.next_pc", 32'(next_pc), 32'h000);
      chk("wrap.imem_addr", 32'(imem_addr), 32'hFFC);
      pc_current = saved_pc; #1;

      // Flush during a stall
      stall = 1'b1;
      tick(); ifid("fs.hold", 12'h080, 1'b1, tag(12'h080));
      flush = 1'b1; #1;
      chk("fs.pc_stall", 32'(pc_stall), 32'h0);
      tick(); flush = 1'b0; stall = 1'b0;
      ifid("fs.bub1", 12'h084, 1'b0, NOP);
      tick(); ifid("fs.bub2", 12'h088, 1'b0, NOP);
      tick(); ifid("fs.pc0", 12'h000, 1'b1, tag(12'h000));
      tick(); ifid("fs.pc4", 12'h004, 1'b1, tag(12'h004));

      // Asynchronous reset in the middle of a stall
      stall = 1'b1;
      tick(); ifid("rs.hold", 12'h004, 1'b1, tag(12'h004));
      #2; reset = 1'b1; #1;
      ifid("rs.async", 12'h000, 1'b0, NOP);
      pc_current = 12'h000; stall = 1'b0;
      tick(); ifid("rs.held", 12'h000, 1'b0, NOP);
      reset = 1'b0;
      tick(); ifid("rs.e1", 12'h000, 1'b0, NOP);
      tick(); ifid("rs.e2", 12'h000, 1'b1, tag(12'h000));
      tick(); ifid("rs.e3", 12'h004, 1'b1, tag(12'h004));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
